// File: rtl/lm32_dtlb_walker.sv
// ---------------------------------------------------------------------------
// lm32_dtlb_walker
//
// Hardware page-table walker for the LM32 data TLB. On a DTLB miss it walks a
// two-level page table (directory entry, then table entry) over a Wishbone
// read master. On success it writes the refill to the DTLB write port. On a
// bad translation or a bus error it raises a fault pulse to the exception
// logic instead of writing.
//
// Entry format (PDE and PTE): [31:12] frame, [1] writable, [0] valid.
//
// Ports
//   clk_i, rst_n_i            clock, async active-low reset
//   enable                    MMU enable; when low a miss is not acted on
//   ptbr                      page-table base (bits 11:0 ignored)
//   miss_i/miss_addr/miss_store  miss request from the X stage
//   abort_i                   cancels a walk that is in flight
//   busy                      walk in progress (feeds LSU stall)
//   done, update              1-cycle refill strobe; tlbvaddr/tlbpaddr valid
//   fault, fault_cause        1-cycle fault pulse; cause held until next walk
//                             (00 bus err, 01 PDE invalid, 10 PTE invalid,
//                              11 write-protect)
//   ptw_*                     Wishbone classic read master
//
// Build option
//   LM32_DTLB_WALKER_WPROT_EN  when defined, a store miss that hits a PTE
//                              with writable=0 faults with cause 11.
//
// State table
//   S_IDLE  | waiting for an enabled miss
//   S_PDE   | directory entry read outstanding
//   S_PTE   | table entry read outstanding
//   S_WRITE | refill strobe to DTLB
//   S_FAULT | fault strobe to exception logic
// ---------------------------------------------------------------------------
module lm32_dtlb_walker #(
  parameter int page_size = 4096,
  parameter int dir_bits  = 10,
  parameter int tbl_bits  = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable,
  input  logic [31:0] ptbr,
  input  logic        miss_i,
  input  logic [31:0] miss_addr,
  input  logic        miss_store,
  input  logic        abort_i,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] tlbvaddr,
  output logic [31:0] tlbpaddr,
  output logic        update,
  output logic [31:0] ptw_adr_o,
  output logic        ptw_cyc_o,
  output logic        ptw_stb_o,
  input  logic [31:0] ptw_dat_i,
  input  logic        ptw_ack_i,
  input  logic        ptw_err_i
);

  localparam int offset_width = $clog2(page_size);
  localparam int vpn_width    = 32 - offset_width;

  localparam logic [1:0] CAUSE_BUS   = 2'b00;
  localparam logic [1:0] CAUSE_PDE   = 2'b01;
  localparam logic [1:0] CAUSE_PTE   = 2'b10;
  localparam logic [1:0] CAUSE_WPROT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PDE,
    S_PTE,
    S_WRITE,
    S_FAULT
  } state_t;

  state_t                r_state;
  logic [vpn_width-1:0]  r_vpn;
  logic                  r_store;
  logic [31:0]           r_adr;
  logic                  r_cyc;
  logic                  r_update;
  logic                  r_fault;
  logic [1:0]            r_cause;
  logic [31:0]           r_vaddr;
  logic [31:0]           r_paddr;

  logic [31:0]           w_pde_adr;
  logic [31:0]           w_pte_adr;
  logic                  w_wprot_fault;
  logic                  w_unused;

  // Directory index comes straight from the incoming miss address so the
  // first request can be issued in the cycle after the miss is sampled.
  assign w_pde_adr = {ptbr[31:offset_width], miss_addr[31 -: dir_bits], 2'b00};
  assign w_pte_adr = {ptw_dat_i[31:offset_width], r_vpn[tbl_bits-1:0], 2'b00};

`ifdef LM32_DTLB_WALKER_WPROT_EN
  assign w_wprot_fault = r_store & ~ptw_dat_i[1];
`else
  assign w_wprot_fault = 1'b0;
`endif

  assign w_unused = ^{ptbr[offset_width-1:0], miss_addr[offset_width-1:0],
                      ptw_dat_i[offset_width-1:1], r_store};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_vpn    <= '0;
      r_store  <= 1'b0;
      r_adr    <= '0;
      r_cyc    <= 1'b0;
      r_update <= 1'b0;
      r_fault  <= 1'b0;
      r_cause  <= '0;
      r_vaddr  <= '0;
      r_paddr  <= '0;
    end else begin
      r_update <= 1'b0;
      r_fault  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && miss_i) begin
            r_vpn   <= miss_addr[31:offset_width];
            r_store <= miss_store;
            r_adr   <= w_pde_adr;
            r_cyc   <= 1'b1;
            r_cause <= '0;
            r_state <= S_PDE;
          end
        end
        S_PDE: begin
          // abort beats ack/err; err beats ack
          if (abort_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
          end else if (ptw_err_i) begin
            r_cyc   <= 1'b0;
            r_fault <= 1'b1;
            r_cause <= CAUSE_BUS;
            r_state <= S_FAULT;
          end else if (ptw_ack_i) begin
            if (!ptw_dat_i[0]) begin
              r_cyc   <= 1'b0;
              r_fault <= 1'b1;
              r_cause <= CAUSE_PDE;
              r_state <= S_FAULT;
            end else begin
              // cyc stays up; the new address appears the cycle after the ack
              r_adr   <= w_pte_adr;
              r_state <= S_PTE;
            end
          end
        end
        S_PTE: begin
          if (abort_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
          end else if (ptw_err_i) begin
            r_cyc   <= 1'b0;
            r_fault <= 1'b1;
            r_cause <= CAUSE_BUS;
            r_state <= S_FAULT;
          end else if (ptw_ack_i) begin
            r_cyc <= 1'b0;
            if (!ptw_dat_i[0]) begin
              r_fault <= 1'b1;
              r_cause <= CAUSE_PTE;
              r_state <= S_FAULT;
            end else if (w_wprot_fault) begin
              r_fault <= 1'b1;
              r_cause <= CAUSE_WPROT;
              r_state <= S_FAULT;
            end else begin
              r_vaddr  <= {r_vpn, {offset_width{1'b0}}};
              r_paddr  <= {ptw_dat_i[31:offset_width], {offset_width{1'b0}}};
              r_update <= 1'b1;
              r_state  <= S_WRITE;
            end
          end
        end
        S_WRITE: r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: begin
          r_cyc   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_update;
  assign update      = r_update;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign tlbvaddr    = r_vaddr;
  assign tlbpaddr    = r_paddr;
  assign ptw_adr_o   = r_adr;
  assign ptw_cyc_o   = r_cyc;
  assign ptw_stb_o   = r_cyc;

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Testbench for lm32_dtlb_walker: Wishbone memory responder with
// programmable wait states and error injection, plus a scoreboard of
// expected bus addresses and refill/fault results.
module tb_lm32_dtlb_walker;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        enable;
  logic [31:0] ptbr;
  logic        miss_i;
  logic [31:0] miss_addr;
  logic        miss_store;
  logic        abort_i;
  logic        busy, done, fault, update;
  logic [1:0]  fault_cause;
  logic [31:0] tlbvaddr, tlbpaddr;
  logic [31:0] ptw_adr_o;
  logic        ptw_cyc_o, ptw_stb_o;
  logic [31:0] ptw_dat_i;
  logic        ptw_ack_i, ptw_err_i;

  lm32_dtlb_walker dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable(enable), .ptbr(ptbr),
    .miss_i(miss_i), .miss_addr(miss_addr), .miss_store(miss_store),
    .abort_i(abort_i), .busy(busy), .done(done), .fault(fault),
    .fault_cause(fault_cause), .tlbvaddr(tlbvaddr), .tlbpaddr(tlbpaddr),
    .update(update), .ptw_adr_o(ptw_adr_o), .ptw_cyc_o(ptw_cyc_o),
    .ptw_stb_o(ptw_stb_o), .ptw_dat_i(ptw_dat_i), .ptw_ack_i(ptw_ack_i),
    .ptw_err_i(ptw_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [31:0] va;
    logic [31:0] pa;
  } res_t;

  res_t        res_q[$];
  logic [31:0] adr_q[$];
  logic [31:0] mem[logic [31:0]];

  int          n_vec = 0;
  int          n_miscmp = 0;
  int          wait_states = 0;
  bit          err_en = 0;
  logic [31:0] err_adr = '0;
  bit          force_ack = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic exp_adr(input logic [31:0] a);
    adr_q.push_back(a);
  endtask

  task automatic exp_refill(input logic [31:0] va, input logic [31:0] pa);
    res_t r;
    r.is_fault = 0; r.cause = 2'b00; r.va = va; r.pa = pa;
    res_q.push_back(r);
  endtask

  task automatic exp_fault(input logic [1:0] c);
    res_t r;
    r.is_fault = 1; r.cause = c; r.va = '0; r.pa = '0;
    res_q.push_back(r);
  endtask

  // Drive a one-cycle miss; returns at the negedge of cycle 1.
  task automatic start_miss(input logic [31:0] va, input logic st);
    @(negedge clk_i);
    miss_addr = va; miss_store = st; miss_i = 1'b1;
    @(negedge clk_i);
    miss_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Memory responder
  initial begin
    int wcnt = 0;
    ptw_ack_i = 1'b0; ptw_err_i = 1'b0; ptw_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      ptw_ack_i = 1'b0; ptw_err_i = 1'b0; ptw_dat_i = '0;
      if (force_ack) begin
        ptw_ack_i = 1'b1;
        ptw_dat_i = 32'h0020_0001;
      end else if (ptw_cyc_o) begin
        if (wcnt >= wait_states) begin
          wcnt = 0;
          ptw_ack_i = 1'b1;
          ptw_dat_i = mem.exists(ptw_adr_o) ? mem[ptw_adr_o] : 32'h0;
          if (err_en && ptw_adr_o == err_adr) ptw_err_i = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (ptw_cyc_o && (ptw_ack_i || ptw_err_i)) begin
        chk("stb_eq_cyc", ptw_stb_o, ptw_cyc_o);
        chk("adr_expected", adr_q.size() != 0, 1'b1);
        if (adr_q.size() != 0) chk("adr", ptw_adr_o, adr_q.pop_front());
      end
      if (update || fault || done) begin
        chk("done_eq_update", done, update);
        chk("result_expected", res_q.size() != 0, 1'b1);
        if (res_q.size() != 0) begin
          res_t r;
          r = res_q.pop_front();
          chk("result_kind", fault, r.is_fault);
          if (r.is_fault) begin
            chk("fault_cause", fault_cause, r.cause);
            chk("fault_no_update", update, 1'b0);
          end else begin
            chk("tlbvaddr", tlbvaddr, r.va);
            chk("tlbpaddr", tlbpaddr, r.pa);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit seen;
    bit dropped;
    rst_n_i = 1'b0; enable = 1'b0; ptbr = 32'h0010_0ABC;  // low bits must be ignored
    miss_i = 1'b0; miss_addr = '0; miss_store = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cyc", ptw_cyc_o, 1'b0);
    chk("rst_adr", ptw_adr_o, 32'h0);
    chk("rst_vaddr", tlbvaddr, 32'h0);
    chk("rst_paddr", tlbpaddr, 32'h0);
    chk("rst_update", update, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_cause", fault_cause, 2'b00);
    rst_n_i = 1'b1; enable = 1'b1;

    // 1: zero-wait refill with latency check
    mem[32'h0010_0004] = 32'h0020_0001;
    mem[32'h0020_000C] = 32'h0ABC_D003;
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
    exp_refill(32'h0040_3000, 32'h0ABC_D000);
    start_miss(32'h0040_3ABC, 1'b0);
    chk("t1_busy_c1", busy, 1'b1);
    chk("t1_upd_c1", update, 1'b0);
    @(negedge clk_i);
    chk("t1_upd_c2", update, 1'b0);
    @(negedge clk_i);
    chk("t1_upd_c3", update, 1'b1);
    @(negedge clk_i);
    chk("t1_busy_c4", busy, 1'b0);
    chk("t1_cyc_c4", ptw_cyc_o, 1'b0);

    // 2: invalid PDE
    mem[32'h0010_0004] = 32'h0020_0000;
    exp_adr(32'h0010_0004); exp_fault(2'b01);
    start_miss(32'h0040_3ABC, 1'b0);
    @(negedge clk_i);
    chk("t2_fault_c2", fault, 1'b1);
    @(negedge clk_i);
    chk("t2_busy_c3", busy, 1'b0);

    // 3a: invalid PTE, cause held afterwards
    mem[32'h0010_0004] = 32'h0020_0001;
    mem[32'h0020_000C] = 32'h0ABC_D000;
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C); exp_fault(2'b10);
    start_miss(32'h0040_3ABC, 1'b0);
    wait_idle("t3a_idle", 20);
    repeat (3) @(negedge clk_i);
    chk("t3a_cause_held", fault_cause, 2'b10);

    // 3b: bus error (with ack) on PDE read
    err_en = 1; err_adr = 32'h0010_0004;
    exp_adr(32'h0010_0004); exp_fault(2'b00);
    start_miss(32'h0040_3ABC, 1'b0);
    wait_idle("t3b_idle", 20);

    // 3c: bus error on PTE read
    mem[32'h0020_000C] = 32'h0ABC_D003;
    err_adr = 32'h0020_000C;
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C); exp_fault(2'b00);
    start_miss(32'h0040_3ABC, 1'b0);
    wait_idle("t3c_idle", 20);
    err_en = 0;

    // 4: abort coincident with PTE ack, then a stray ack in IDLE
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
    start_miss(32'h0040_3ABC, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk_i);
      #2;
      if (ptw_cyc_o && ptw_ack_i && ptw_adr_o == 32'h0020_000C) found = 1;
    end
    chk("t4_pte_ack_seen", found, 1'b1);
    abort_i = 1'b1;
    @(posedge clk_i);
    #2;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("t4_cyc_dropped", ptw_cyc_o, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_no_update", update, 1'b0);
    chk("t4_no_fault", fault, 1'b0);
    force_ack = 1;
    @(negedge clk_i);
    force_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_stray_busy", busy, 1'b0);
    end

    // 5: write protection
    mem[32'h0020_000C] = 32'h0ABC_D001;
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
`ifdef LM32_DTLB_WALKER_WPROT_EN
    exp_fault(2'b11);
`else
    exp_refill(32'h0040_3000, 32'h0ABC_D000);
`endif
    start_miss(32'h0040_3ABC, 1'b1);
    wait_idle("t5a_idle", 20);
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
    exp_refill(32'h0040_3000, 32'h0ABC_D000);
    start_miss(32'h0040_3ABC, 1'b0);
    wait_idle("t5b_idle", 20);
    mem[32'h0020_000C] = 32'h0ABC_D003;
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
    exp_refill(32'h0040_3000, 32'h0ABC_D000);
    start_miss(32'h0040_3ABC, 1'b1);
    wait_idle("t5c_idle", 20);

    // 6: 3 wait states, second miss and enable drop mid-walk
    wait_states = 3;
    mem[32'h0010_0008] = 32'h0030_0001;
    mem[32'h0030_0014] = 32'h0DEF_0001;
    exp_adr(32'h0010_0008); exp_adr(32'h0030_0014);
    exp_refill(32'h0080_5000, 32'h0DEF_0000);
    start_miss(32'h0080_5123, 1'b0);
    seen = 0; dropped = 0;
    for (int c = 1; c <= 14 && !seen; c++) begin
      miss_i = (c == 2);
      if (c == 2) miss_addr = 32'h0040_3ABC;
      if (c == 4) enable = 1'b0;
      if (update) begin
        seen = 1;
        chk("t6_done_cycle", c, 9);
      end else begin
        if (!busy) dropped = 1;
        @(negedge clk_i);
      end
    end
    miss_i = 1'b0;
    chk("t6_refill_seen", seen, 1'b1);
    chk("t6_busy_continuous", dropped, 1'b0);
    wait_idle("t6_idle", 20);
    start_miss(32'h0040_3ABC, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_disabled_busy", busy, 1'b0);
      @(negedge clk_i);
    end
    enable = 1'b1;

    // 7: async reset mid-walk clears everything at once
    start_miss(32'h0040_3ABC, 1'b0);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_cyc", ptw_cyc_o, 1'b0);
    chk("t7_adr", ptw_adr_o, 32'h0);
    chk("t7_vaddr", tlbvaddr, 32'h0);
    chk("t7_paddr", tlbpaddr, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    wait_states = 0;

    // 8: walk after reset still works
    exp_adr(32'h0010_0004); exp_adr(32'h0020_000C);
    exp_refill(32'h0040_3000, 32'h0ABC_D000);
    start_miss(32'h0040_3ABC, 1'b0);
    wait_idle("t8_idle", 20);

    repeat (4) @(negedge clk_i);
    chk("adr_q_drained", adr_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
